pll_lock_ctrl: RTL
==================

# pll_lock_ctrl

Synthesizable power-up sequencer that drives a PLL's enable input and qualifies its lock output for downstream logic. It sits between system reset and the PLL primitive, on the PLL's reference clock. It asserts PLL_EN and waits for LOCK with a timeout, retrying a bounded number of times. After lock it releases a settled ready flag and a downstream reset. It also detects loss of lock at run time and re-sequences the PLL.

## Interface
- LOCK_TIMEOUT, 1024: cycles in ENABLE without synced lock before an attempt fails (≥2).
- SETTLE_CYCLES, 16: cycles synced lock must stay high before READY (≥1).
- PWRDN_CYCLES, 8: cycles PLL_EN is held low between attempts (≥1).
- MAX_RETRIES, 3: failed attempts tolerated before FAULT (0–15).

- CLK_IN  input  1  reference clock, same net as the PLL's CLK_IN.
- RST_N  input  1  reset; synchronous, active-low.
- START  input  1  level request; high = bring the PLL up and keep it up.
- LOCK  input  1  PLL lock; asynchronous to CLK_IN, synchronized internally.
- PLL_EN  output  1  drives the PLL enable.
- PLL_READY  output  1  PLL locked and settled.
- CLK_RST_N  output  1  active-low reset for logic on the PLL output clocks; equals ~PLL_READY.
- FAULT  output  1  retries exhausted; sticky until START is low.
- RETRY_CNT  output  4  failed attempts since the last entry to RUN or IDLE.

## Operation
- lock_s: LOCK passed through two flops. All decisions use lock_s only.
- States:
  - IDLE: PLL_EN=0.
  - ENABLE: PLL_EN=1; counter counts up.
  - SETTLE: PLL_EN=1; counter counts up.
  - RUN: PLL_EN=1, PLL_READY=1.
  - PWRDN: PLL_EN=0; counter counts up.
  - FAULT: PLL_EN=0, FAULT=1.
- Outputs are decoded from the registered state (Moore). There are no combinational paths from inputs to outputs.
- Transitions:
  - IDLE → ENABLE when START=1. The counter clears.
  - ENABLE → SETTLE when lock_s=1. The counter clears.
  - ENABLE, no lock_s, counter = LOCK_TIMEOUT−1 → PWRDN if RETRY_CNT < MAX_RETRIES (RETRY_CNT +1), else FAULT.
  - SETTLE → ENABLE if lock_s drops. The counter clears; RETRY_CNT is unchanged.
  - SETTLE → RUN when the counter reaches SETTLE_CYCLES−1 with lock_s=1. RETRY_CNT clears.
  - RUN → PWRDN when lock_s=0. RETRY_CNT +1, and the MAX_RETRIES check applies as for a timeout.
  - PWRDN → ENABLE when the counter reaches PWRDN_CYCLES−1.
  - Any state except FAULT → IDLE when START=0. Counters and RETRY_CNT clear.
  - FAULT → IDLE only when START=0.
- Priority within one cycle: START=0 > lock_s-based transition > counter terminal count.
- RETRY_CNT saturates at 15. No wrap.
- The shared counter is sized to $clog2 of the largest of the three cycle parameters. It is never compared against a value outside its state's limit.

## Timing
- Reset values (RST_N low at an edge → state IDLE after that edge): PLL_EN=0, PLL_READY=0, CLK_RST_N=0, FAULT=0, RETRY_CNT=0, sync flops=0.
- Reset has priority over all inputs, including when it arrives mid-sequence.
- START high sampled at edge k → PLL_EN=1 after edge k.
- LOCK rising before edge m → lock_s high after m+1 → SETTLE after m+2 → RUN after m+1+SETTLE_CYCLES.
  - PLL_READY=1 and CLK_RST_N=1 from that same edge.
- LOCK falling before edge n while in RUN → PLL_READY=0 and CLK_RST_N=0 after edge n+2. PLL_EN=0 from the same edge.
- Attempt length without lock: exactly LOCK_TIMEOUT cycles of PLL_EN=1, then PWRDN_CYCLES cycles of PLL_EN=0.
- START falling before edge j → PLL_EN=0 and PLL_READY=0 after edge j.

## Structure
- Package pll_ctrl_pkg holds:
  - the state enum (6 encodings);
  - the RETRY_CNT width constant (4);
  - a counter-width function.
- Sub-module pll_lock_sync: a two-flop synchronizer with synchronous active-low reset, instantiated once for LOCK.
- FSM, shared counter and retry counter live in pll_lock_ctrl.

## Test plan
Parameters for all scenarios: LOCK_TIMEOUT=32, SETTLE_CYCLES=4, PWRDN_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: START high at cycle 0, LOCK high at cycle 20 → PLL_EN=1 from cycle 1, PLL_READY=1 and CLK_RST_N=1 at cycle 25, RETRY_CNT=0.
- Lock never arrives: → two timeout/PWRDN pairs (PLL_EN=1 for 32 cycles, 0 for 8, RETRY_CNT 1 then 2), third timeout → FAULT=1, PLL_EN=0. START low → IDLE, FAULT=0.
- Lock glitch during SETTLE: LOCK drops for 3 cycles after sync → back to ENABLE, RETRY_CNT unchanged. RUN reached only after 4 stable cycles.
- Run-time lock loss: LOCK low 2 cycles in RUN → PLL_READY low 2 cycles later, PWRDN for 8 cycles, RETRY_CNT=1, then relock to RUN with RETRY_CNT=0.
- Reset mid-sequence: RST_N low during SETTLE → all outputs at reset values after the next edge. Sequence restarts from IDLE after release.
- START drop in ENABLE in the same cycle as lock_s rises → IDLE; PLL_READY never asserts.

Source files
------------

// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL power-up / lock qualification controller.
// Holds the sequencer state encoding, the retry counter width and the cycle-counter sizing rule.
package pll_ctrl_pkg;

   localparam int RETRY_W = 4;
   localparam logic [RETRY_W-1:0] RETRY_SAT = '1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ENABLE = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RUN    = 3'd3,
      ST_PWRDN  = 3'd4,
      ST_FAULT  = 3'd5
   } pll_state_e;

   // The shared counter only ever has to hold (largest limit - 1); never narrower than one bit.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return ($clog2(m) < 1) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchronizer bringing the PLL's asynchronous lock indication into the reference clock domain.
// Both flops clear on reset so a stale lock can never leak across a reset.
module pll_lock_sync (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_sync
);

   logic r_meta;
   logic r_sync;

   // NOTE: flops are written with non-blocking assignments so both stages sample the old values on the same edge.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_async;
         r_sync <= r_meta;
      end
   end

   assign o_sync = r_sync;

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL power-up sequencer: enables the PLL, waits for lock with timeout and bounded retries,
// qualifies a settled lock into a ready flag / downstream reset, and re-sequences on lock loss.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int LOCK_TIMEOUT  = 1024,
   parameter int SETTLE_CYCLES = 16,
   parameter int PWRDN_CYCLES  = 8,
   parameter int MAX_RETRIES   = 3
) (
   input  logic               i_clk_in,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic               i_lock,
   output logic               o_pll_en,
   output logic               o_pll_ready,
   output logic               o_clk_rst_n,
   output logic               o_fault,
   output logic [RETRY_W-1:0] o_retry_cnt
);

   localparam int CNT_W = cnt_width(LOCK_TIMEOUT, SETTLE_CYCLES, PWRDN_CYCLES);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
   // The ENABLE cycle that first sees lock counts as the first settle cycle, so SETTLE ends one count early.
   localparam logic [CNT_W-1:0]   SETTLE_LAST  = (SETTLE_CYCLES > 2) ? CNT_W'(SETTLE_CYCLES - 2) : '0;
   localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

   pll_state_e         r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [RETRY_W-1:0] r_retry, w_retry_nxt;
   logic [RETRY_W-1:0] w_retry_inc;
   logic               w_lock_s;

   pll_lock_sync u_lock_sync (
      .i_clk   (i_clk_in),
      .i_rst_n (i_rst_n),
      .i_async (i_lock),
      .o_sync  (w_lock_s)
   );

   assign w_retry_inc = (r_retry == RETRY_SAT) ? r_retry : r_retry + 1'b1;

   always_ff @(posedge i_clk_in) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_retry <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_retry <= w_retry_nxt;
      end
   end

   // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_retry_nxt = r_retry;

      if (!i_start) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_retry_nxt = '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_ENABLE;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end
            ST_ENABLE: begin
               if (w_lock_s) begin
                  w_state_nxt = ST_SETTLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == TIMEOUT_LAST) begin
                  w_cnt_nxt = '0;
                  if (r_retry < RETRY_LIMIT) begin
                     w_state_nxt = ST_PWRDN;
                     w_retry_nxt = w_retry_inc;
                  end else begin
                     w_state_nxt = ST_FAULT;
                  end
               end
            end
            ST_SETTLE: begin
               if (!w_lock_s) begin
                  w_state_nxt = ST_ENABLE;
                  w_cnt_nxt   = '0;
               end else if (r_cnt == SETTLE_LAST) begin
                  w_state_nxt = ST_RUN;
                  w_cnt_nxt   = '0;
                  w_retry_nxt = '0;
               end
            end
            ST_RUN: begin
               w_cnt_nxt = '0;
               if (!w_lock_s) begin
                  if (r_retry < RETRY_LIMIT) begin
                     w_state_nxt = ST_PWRDN;
                     w_retry_nxt = w_retry_inc;
                  end else begin
                     w_state_nxt = ST_FAULT;
                  end
               end
            end
            ST_PWRDN: begin
               if (r_cnt == PWRDN_LAST) begin
                  w_state_nxt = ST_ENABLE;
                  w_cnt_nxt   = '0;
               end
            end
            ST_FAULT: begin
               w_cnt_nxt = '0;
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_retry_nxt = '0;
            end
         endcase
      end
   end

   assign o_pll_en    = (r_state == ST_ENABLE) || (r_state == ST_SETTLE) || (r_state == ST_RUN);
   assign o_pll_ready = (r_state == ST_RUN);
   // Downstream reset stays asserted (low) whenever the PLL is not ready.
   assign o_clk_rst_n = (r_state == ST_RUN);
   assign o_fault     = (r_state == ST_FAULT);
   assign o_retry_cnt = r_retry;

endmodule
